// File: rtl/caravel_uart_gpio_if.sv
// Register bus between the management firmware master and the UART/GPIO block.
//   bus_valid : request, held high by the master until bus_ready
//   bus_we    : 1 = write, 0 = read
//   bus_addr  : word index of the register
//   bus_wdata : write data
//   bus_rdata : read data, valid while bus_ready is high
//   bus_ready : one-cycle completion pulse from the slave
`timescale 1ns/1ps
interface caravel_uart_gpio_if;
  logic        bus_valid;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/caravel_uart_gpio.sv
// Management-side UART transmitter (8N1, small TX FIFO) plus a 16-bit GPIO
// check-pattern register for the Caravel SoC.
//   clock    : system clock, rising edge
//   resetb   : asynchronous active-low reset
//   bus      : register bus (slave modport)
//   uart_tx  : serial output, idle high
//   gpio_out : check-pattern outputs
//   gpio_oeb : active-low output enables
//   irq      : TX-done interrupt (level)
`timescale 1ns/1ps
module caravel_uart_gpio #(
  parameter int unsigned DEFAULT_DIV = 4167,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                  clock,
  input  logic                  resetb,
  caravel_uart_gpio_if.slave    bus,
  output logic                  uart_tx,
  output logic [15:0]           gpio_out,
  output logic [15:0]           gpio_oeb,
  output logic                  irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  // Bus and register state
  logic        ready_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic        tx_en_q, irq_en_q, ovf_q, irq_q;
  logic [15:0] div_q, gpio_out_q, gpio_oeb_q;

  // FIFO state
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Shifter state
  tx_state_e   state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic [15:0] baud_cnt_q, bit_len_q;
  logic        line_q;

  logic req, wr, rd, fifo_full, fifo_empty, busy, push, pop, bit_end;
  logic [15:0] div_eff;
  logic [7:0]  fifo_head;
  logic        unused_wdata;

  // A request is only taken when ready is low, so ready never pulses twice in a row.
  assign req        = bus.bus_valid & ~ready_q;
  assign wr         = req & bus.bus_we;
  assign rd         = req & ~bus.bus_we;
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign busy       = (state_q != S_IDLE);
  // Fullness is judged before any same-cycle pop, so a pop never makes room for this write.
  assign push       = wr & (bus.bus_addr == 4'd0) & ~fifo_full;
  assign bit_end    = (baud_cnt_q == bit_len_q - 16'd1);
  assign pop        = tx_en_q & ~fifo_empty &
                      ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_end));
  assign div_eff    = (div_q == 16'd0) ? 16'd1 : div_q;
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign unused_wdata = ^bus.bus_wdata[31:16];

  assign bus.bus_ready = ready_q;
  assign bus.bus_rdata = rdata_q;
  assign uart_tx       = line_q;
  assign gpio_out      = gpio_out_q;
  assign gpio_oeb      = gpio_oeb_q;
  assign irq           = irq_q;

  always_comb begin
    rdata_d = '0;
    case (bus.bus_addr)
      4'd1:    rdata_d = {28'd0, ovf_q, busy, fifo_empty, fifo_full};
      4'd2:    rdata_d = {30'd0, irq_en_q, tx_en_q};
      4'd3:    rdata_d = {16'd0, div_q};
      4'd4:    rdata_d = {16'd0, gpio_out_q};
      4'd5:    rdata_d = {16'd0, ~gpio_oeb_q};
      default: rdata_d = '0;
    endcase
  end

  // Bus handshake and control registers
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      tx_en_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
      div_q      <= 16'(DEFAULT_DIV);
      gpio_out_q <= '0;
      gpio_oeb_q <= 16'hFFFF;
    end else begin
      ready_q <= req;
      rdata_q <= rd ? rdata_d : 32'd0;
      irq_q   <= irq_en_q & fifo_empty & ~busy;
      if (wr) begin
        case (bus.bus_addr)
          4'd0: if (fifo_full) ovf_q <= 1'b1;
          4'd1: if (bus.bus_wdata[3]) ovf_q <= 1'b0;
          4'd2: begin
            tx_en_q  <= bus.bus_wdata[0];
            irq_en_q <= bus.bus_wdata[1];
          end
          4'd3: div_q      <= bus.bus_wdata[15:0];
          4'd4: gpio_out_q <= bus.bus_wdata[15:0];
          4'd5: gpio_oeb_q <= ~bus.bus_wdata[15:0];
          default: ;
        endcase
      end
    end
  end

  // FIFO storage has no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.bus_wdata[7:0];
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Frame shifter. The line register lags the state by one clock, which gives
  // the two-clock write-to-start-bit latency while keeping every bit DIV long.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      baud_cnt_q <= '0;
      bit_len_q  <= 16'd1;
      line_q     <= 1'b1;
    end else begin
      case (state_q)
        S_START: line_q <= 1'b0;
        S_DATA:  line_q <= shift_q[0];
        default: line_q <= 1'b1;
      endcase
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q    <= fifo_head;
            bit_len_q  <= div_eff;
            baud_cnt_q <= '0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            state_q    <= S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            shift_q    <= shift_q >> 1;
            bit_idx_q  <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            // Chain straight into the next start bit when data is waiting.
            if (pop) begin
              shift_q   <= fifo_head;
              bit_len_q <= div_eff;
              state_q   <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_caravel_uart_gpio.sv
`timescale 1ns/1ps
module tb_caravel_uart_gpio;
  logic        clock;
  logic        resetb;
  logic        uart_tx;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oeb;
  logic        irq;

  caravel_uart_gpio_if bus_if ();

  caravel_uart_gpio #(.DEFAULT_DIV(4167), .FIFO_DEPTH(4)) dut (
    .clock    (clock),
    .resetb   (resetb),
    .bus      (bus_if),
    .uart_tx  (uart_tx),
    .gpio_out (gpio_out),
    .gpio_oeb (gpio_oeb),
    .irq      (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Serial decoder (tbuart) for a bit period of 4 clocks.
  logic [7:0] rx_q [$];
  time        rx_start_q [$];

  initial begin
    logic [7:0] b;
    time        t0;
    forever begin
      @(negedge uart_tx);
      t0 = $time;
      repeat (2) @(posedge clock);
      #1;
      for (int k = 0; k < 8; k++) begin
        repeat (4) @(posedge clock);
        #1;
        b[k] = uart_tx;
      end
      repeat (4) @(posedge clock);
      #1;
      rx_q.push_back(b);
      rx_start_q.push_back(t0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    int n;
    @(negedge clock);
    bus_if.bus_valid = 1'b1;
    bus_if.bus_we    = 1'b1;
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = d;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!bus_if.bus_ready && n < 8);
    check("wr_ready", {31'd0, bus_if.bus_ready}, 32'd1);
    bus_if.bus_valid = 1'b0;
    bus_if.bus_we    = 1'b0;
    $display("WR addr=%0d data=%08h", a, d);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    @(negedge clock);
    bus_if.bus_valid = 1'b1;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = a;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!bus_if.bus_ready && n < 8);
    d = bus_if.bus_rdata;
    if (!bus_if.bus_ready) check("rd_ready", 32'd0, 32'd1);
    bus_if.bus_valid = 1'b0;
    $display("RD addr=%0d data=%08h", a, d);
  endtask

  initial begin
    logic [31:0] rd;
    logic [9:0]  frame;
    string       msg;
    logic [7:0]  ovf_bytes [5];
    int          n;

    bus_if.bus_valid = 1'b0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = '0;
    bus_if.bus_wdata = '0;

    // Reset
    resetb = 1'b0;
    #1000;
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_gpio_out", {16'd0, gpio_out}, 32'h0000_0000);
    check("rst_gpio_oeb", {16'd0, gpio_oeb}, 32'h0000_FFFF);
    check("rst_ready", {31'd0, bus_if.bus_ready}, 32'd0);
    check("rst_rdata", bus_if.bus_rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clock);
    resetb = 1'b1;
    bus_read(4'd3, rd); check("rst_div", rd, 32'd4167);
    bus_read(4'd1, rd); check("rst_status", rd, 32'h2);
    bus_read(4'd2, rd); check("rst_ctrl", rd, 32'h0);

    // Check pattern
    bus_write(4'd5, 32'h0000_FFFF);
    bus_write(4'd4, 32'h0000_A000);
    check("gpio_started", {16'd0, gpio_out}, 32'h0000_A000);
    check("gpio_oeb_on", {16'd0, gpio_oeb}, 32'h0000_0000);
    bus_write(4'd4, 32'hFFFF_AB00);
    check("gpio_passed", {16'd0, gpio_out}, 32'h0000_AB00);
    bus_read(4'd4, rd); check("gpio_readback", rd, 32'h0000_AB00);
    bus_read(4'd5, rd); check("gpio_oe_readback", rd, 32'h0000_FFFF);
    bus_write(4'd9, 32'h1234_5678);
    bus_read(4'd9, rd); check("unmapped_read", rd, 32'd0);
    bus_read(4'd0, rd); check("txdata_read", rd, 32'd0);

    // Single frame, 0x4D at DIV=4
    bus_write(4'd3, 32'hABCD_0004);
    bus_read(4'd3, rd); check("div_readback", rd, 32'd4);
    bus_write(4'd2, 32'h3);
    frame = 10'b1_0100_1101_0;   // stop, data MSB..LSB, start (bit 0 sent first)
    bus_write(4'd0, 32'h0000_004D);
    check("latency_n", {31'd0, uart_tx}, 32'd1);
    @(posedge clock); #1;
    check("latency_n1", {31'd0, uart_tx}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      check($sformatf("frame_bit%0d_clk%0d", i / 4, i % 4), {31'd0, uart_tx}, {31'd0, frame[i / 4]});
      if (i == 20) check("irq_mid_frame", {31'd0, irq}, 32'd0);
    end
    bus_read(4'd1, rd); check("status_after_frame", rd, 32'h2);
    check("irq_done", {31'd0, irq}, 32'd1);

    // Burst with full polling
    msg = "Monitor: Test UART passed";
    rx_q.delete();
    rx_start_q.delete();
    for (int i = 0; i < msg.len(); i++) begin
      n = 0;
      do begin
        bus_read(4'd1, rd);
        n++;
      end while (rd[0] && n < 100);
      check("poll_not_full", {31'd0, rd[0]}, 32'd0);
      bus_write(4'd0, {24'd0, msg[i]});
    end
    n = 0;
    while (rx_q.size() < msg.len() && n < 3000) begin
      @(posedge clock); n++;
    end
    check("burst_count", rx_q.size(), msg.len());
    for (int i = 0; i < rx_q.size() && i < msg.len(); i++)
      check($sformatf("burst_char%0d", i), {24'd0, rx_q[i]}, {24'd0, msg[i]});
    for (int i = 1; i < rx_start_q.size(); i++)
      check($sformatf("burst_gap%0d", i), 32'(rx_start_q[i] - rx_start_q[i-1]), 32'd400);

    // Overflow with transmitter disabled
    bus_write(4'd2, 32'h0);
    ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) bus_write(4'd0, {24'd0, ovf_bytes[i]});
    bus_read(4'd1, rd); check("status_overflow", rd, 32'h9);
    bus_write(4'd1, 32'h8);
    bus_read(4'd1, rd); check("status_ovf_cleared", rd, 32'h1);
    rx_q.delete();
    rx_start_q.delete();
    bus_write(4'd2, 32'h1);
    n = 0;
    while (rx_q.size() < 4 && n < 600) begin
      @(posedge clock); n++;
    end
    repeat (60) @(posedge clock);
    #1;
    check("ovf_kept_count", rx_q.size(), 32'd4);
    for (int i = 0; i < rx_q.size() && i < 4; i++)
      check($sformatf("ovf_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, ovf_bytes[i]});
    bus_read(4'd1, rd); check("status_drained", rd, 32'h2);

    // Reset during DATA bit 3 of 0xA5, with a second byte queued
    bus_write(4'd0, 32'hA5);
    bus_write(4'd0, 32'h5A);
    repeat (17) @(posedge clock);
    #1;
    check("data_bit3_before_reset", {31'd0, uart_tx}, 32'd0);
    #1;
    resetb = 1'b0;
    #1;
    check("uart_tx_on_reset", {31'd0, uart_tx}, 32'd1);
    check("gpio_out_on_reset", {16'd0, gpio_out}, 32'd0);
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    bus_read(4'd1, rd); check("status_after_reset", rd, 32'h2);
    bus_read(4'd3, rd); check("div_after_reset", rd, 32'd4167);
    repeat (20) @(posedge clock);
    #1;
    check("idle_after_reset", {31'd0, uart_tx}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/caravel_uart_gpio.md
# caravel_uart_gpio

Management-side UART transmitter and GPIO check-pattern register block for the Caravel SoC. Firmware writes bytes over a simple register bus. The block serialises them as 8N1 frames on the user-project TX pad (mprj_io[6]). A 16-bit GPIO output register drives mprj_io[31:16], which benches use to report test progress (0xA000 = started, 0xAB00 = passed).

## Interface
- DEFAULT_DIV, 4167: reset value of DIV; bit period in clocks (40 MHz / 9600 baud).
- FIFO_DEPTH, 4: TX FIFO entries (power of two, ≥2).
- clock  in  1  system clock, rising-edge.
- resetb  in  1  asynchronous active-low reset.
- bus_valid  in  1  request; held high until bus_ready.
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  4  word index.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, valid while bus_ready = 1.
- bus_ready  out  1  one-cycle completion pulse.
- uart_tx  out  1  serial output, idle high.
- gpio_out  out  16  check-pattern outputs.
- gpio_oeb  out  16  active-low output enables.
- irq  out  1  TX-done interrupt, level.

## Operation
- Register map (word index):
  - 0 TXDATA: write pushes wdata[7:0]; read returns 0.
  - 1 STATUS (read only, except bit 3):
    - [0] full
    - [1] fifo empty
    - [2] busy (frame in progress)
    - [3] overflow, sticky; write 1 to clear.
  - 2 CTRL: [0] tx_en, [1] irq_en.
  - 3 DIV: [15:0].
  - 4 GPIO_OUT: [15:0].
  - 5 GPIO_OE: [15:0], active-high; gpio_oeb = ~GPIO_OE.
  - Other indices read 0; writes to them are ignored.
  - Unused register bits read 0.
- Write to TXDATA while full: byte dropped, overflow set. A same-cycle pop frees no space for that write.
- Frame format: start bit 0, data bits LSB first, stop bit 1. Each bit lasts max(DIV,1) clocks.
- DIV is sampled at frame start. Changing DIV mid-frame affects only the next frame.
- Shifter states: IDLE → START → DATA(8) → STOP → IDLE.
- Frame start: from IDLE, when tx_en=1 and the FIFO is non-empty, pop the head and load the shifter.
- Back-to-back frames: when STOP ends and the FIFO is non-empty, the next START begins on the following clock with no idle gap.
- Clearing tx_en mid-frame: the current frame completes; no new pops occur.
- irq = irq_en & fifo_empty & ~busy.

## Timing
- Reset values:
  - uart_tx = 1
  - gpio_out = 0
  - gpio_oeb = 16'hFFFF
  - bus_ready = 0, bus_rdata = 0, irq = 0
  - CTRL = 0, DIV = DEFAULT_DIV, FIFO empty, overflow = 0, shifter IDLE.
- Bus handshake:
  - bus_valid sampled high at edge N with bus_ready low → bus_ready high for exactly cycle N+1.
  - Write takes effect at edge N.
  - Read data is registered at edge N.
  - The master deasserts or changes the request after ready. Ready never asserts on two consecutive cycles.
- TX latency: a TXDATA write accepted at edge N, with tx_en=1 and the shifter IDLE, drives uart_tx low from edge N+2. Frame is 10·DIV clocks.
- GPIO_OUT and GPIO_OE writes appear on the pins from edge N.
- resetb assertion mid-frame aborts the frame immediately: uart_tx = 1 and the FIFO is flushed.
- All outputs are registered. irq changes one clock after its terms change.

## Test plan
- Reset: hold resetb low 1000 ns → uart_tx=1, gpio_out=0, gpio_oeb=FFFF; DIV reads 4167.
- Check pattern: write GPIO_OE=FFFF, then GPIO_OUT=A000 → pins show A000 and gpio_oeb=0. Then write AB00 → pins show AB00.
- Single frame: DIV=4, tx_en=1, write 0x4D → uart_tx sequence 0,1,0,1,1,0,0,1,0,1, each bit 4 clocks. busy clears 40 clocks after the start bit; irq rises with irq_en=1.
- Burst: "Monitor: Test UART passed" written byte-by-byte with STATUS.full polling → tbuart decodes the exact string with no gaps between frames.
- Overflow: tx_en=0, write 5 bytes → full=1, overflow=1, 4 entries kept. Write 1 to STATUS[3] → overflow=0.
- Reset mid-frame: assert resetb during DATA bit 3 → uart_tx=1 immediately, STATUS reads fifo empty and not busy after release.
